// File: rtl/pad_input_conditioner.sv
// rtl/pad_input_conditioner.sv - pad input synchronizer plus usr_btn debouncer.
// Define PAD_INPUT_CONDITIONER_GLITCH_FILTER_EN to add a 3-sample majority filter on the GPIO path.
module pad_input_conditioner #(
  parameter int GPIO_W          = 20,
  parameter int DEBOUNCE_CYCLES = 480000,
  parameter int BTN_ACTIVE_LOW  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [GPIO_W-1:0] gpio_in_raw,
  input  logic              btn_raw,
  output logic [GPIO_W-1:0] gpio_in_sync,
  output logic              btn_level,
  output logic              btn_press,
  output logic              btn_release
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic BTN_IDLE = (BTN_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    RELEASED,
    CHK_PRESS,
    PRESSED,
    CHK_RELEASE
  } state_t;

  logic [GPIO_W-1:0] gpio_s1;
  logic [GPIO_W-1:0] gpio_s2;
  logic              btn_s1;
  logic              btn_s2;
  logic              btn_n;

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_next;
  logic              level_next;
  logic              press_next;
  logic              release_next;

  // Button flops reset to the released level so reset exit never looks like a press.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gpio_s1 <= '0;
      gpio_s2 <= '0;
      btn_s1  <= BTN_IDLE;
      btn_s2  <= BTN_IDLE;
    end else begin
      gpio_s1 <= gpio_in_raw;
      gpio_s2 <= gpio_s1;
      btn_s1  <= btn_raw;
      btn_s2  <= btn_s1;
    end
  end

`ifdef PAD_INPUT_CONDITIONER_GLITCH_FILTER_EN
  logic [GPIO_W-1:0] flt_d1;
  logic [GPIO_W-1:0] flt_d2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flt_d1       <= '0;
      flt_d2       <= '0;
      gpio_in_sync <= '0;
    end else begin
      flt_d1       <= gpio_s2;
      flt_d2       <= flt_d1;
      gpio_in_sync <= (gpio_s2 & flt_d1) | (gpio_s2 & flt_d2) | (flt_d1 & flt_d2);
    end
  end
`else
  assign gpio_in_sync = gpio_s2;
`endif

  assign btn_n = (BTN_ACTIVE_LOW != 0) ? ~btn_s2 : btn_s2;

  // Counter only advances below CNT_LAST, so it saturates instead of wrapping.
  always_comb begin
    state_next = state;
    count_next = count;
    case (state)
      RELEASED: begin
        if (btn_n) begin
          state_next = CHK_PRESS;
          count_next = '0;
        end
      end
      CHK_PRESS: begin
        if (!btn_n) begin
          state_next = RELEASED;
        end else if (count == CNT_LAST) begin
          state_next = PRESSED;
        end else begin
          count_next = count + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (!btn_n) begin
          state_next = CHK_RELEASE;
          count_next = '0;
        end
      end
      CHK_RELEASE: begin
        if (btn_n) begin
          state_next = PRESSED;
        end else if (count == CNT_LAST) begin
          state_next = RELEASED;
        end else begin
          count_next = count + CNT_W'(1);
        end
      end
      default: begin
        state_next = RELEASED;
        count_next = '0;
      end
    endcase
    level_next   = (state_next == PRESSED) || (state_next == CHK_RELEASE);
    press_next   = (state == CHK_PRESS) && (state_next == PRESSED);
    release_next = (state == CHK_RELEASE) && (state_next == RELEASED);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= RELEASED;
      count       <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
    end else begin
      state       <= state_next;
      count       <= count_next;
      btn_level   <= level_next;
      btn_press   <= press_next;
      btn_release <= release_next;
    end
  end

endmodule

// File: tb/tb_pad_input_conditioner.sv
// tb/tb_pad_input_conditioner.sv - self-checking bench for pad_input_conditioner.
// Follows PAD_INPUT_CONDITIONER_GLITCH_FILTER_EN to pick the expected GPIO latency.
module tb_pad_input_conditioner;
  localparam int W = 20;
  localparam int N = 4;
`ifdef PAD_INPUT_CONDITIONER_GLITCH_FILTER_EN
  localparam bit FILT = 1'b1;
  localparam int LAT  = 4;
`else
  localparam bit FILT = 1'b0;
  localparam int LAT  = 2;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] gpio_in_raw;
  logic         btn_raw;
  logic [W-1:0] gpio_in_sync;
  logic         btn_level;
  logic         btn_press;
  logic         btn_release;

  pad_input_conditioner #(
    .GPIO_W(W),
    .DEBOUNCE_CYCLES(N),
    .BTN_ACTIVE_LOW(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .gpio_in_raw(gpio_in_raw),
    .btn_raw(btn_raw),
    .gpio_in_sync(gpio_in_sync),
    .btn_level(btn_level),
    .btn_press(btn_press),
    .btn_release(btn_release)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: raw input history per edge, plus a run-length debouncer.
  logic [W-1:0] gh [5];
  logic         bh [5];
  logic [W-1:0] m_gpio;
  logic         m_level;
  logic         m_press;
  logic         m_release;
  int           m_run;

  typedef struct {
    logic [W-1:0] g;
    logic         b;
    logic [W-1:0] eg;
    logic         el;
    logic         ep;
    logic         er;
  } vec_t;

  vec_t tbl [20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 5; i++) begin
      gh[i] = '0;
      bh[i] = 1'b1;
    end
    m_gpio    = '0;
    m_level   = 1'b0;
    m_press   = 1'b0;
    m_release = 1'b0;
    m_run     = 0;
  endtask

  task automatic model_edge(input logic [W-1:0] g, input logic b);
    logic samp;
    for (int i = 0; i < 4; i++) begin
      gh[i] = gh[i+1];
      bh[i] = bh[i+1];
    end
    gh[4] = g;
    bh[4] = b;
    m_gpio = FILT ? ((gh[2] & gh[1]) | (gh[2] & gh[0]) | (gh[1] & gh[0])) : gh[3];
    samp      = ~bh[2];
    m_press   = 1'b0;
    m_release = 1'b0;
    if (samp != m_level) begin
      m_run++;
      if (m_run == N + 1) begin
        m_level   = samp;
        m_run     = 0;
        m_press   = samp;
        m_release = ~samp;
      end
    end else begin
      m_run = 0;
    end
  endtask

  task automatic tick(input logic [W-1:0] g, input logic b);
    gpio_in_raw = g;
    btn_raw     = b;
    @(posedge clk);
    #1;
    model_edge(g, b);
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_gpio"}, 32'(gpio_in_sync), 32'(m_gpio));
    chk({tag, "_level"}, 32'(btn_level), 32'(m_level));
    chk({tag, "_press"}, 32'(btn_press), 32'(m_press));
    chk({tag, "_release"}, 32'(btn_release), 32'(m_release));
    chk({tag, "_excl"}, 32'(btn_press & btn_release), 32'd0);
  endtask

  task automatic do_reset(input string tag);
    rst_n       = 1'b0;
    gpio_in_raw = '0;
    btn_raw     = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    chk({tag, "_gpio"}, 32'(gpio_in_sync), 32'd0);
    chk({tag, "_level"}, 32'(btn_level), 32'd0);
    chk({tag, "_press"}, 32'(btn_press), 32'd0);
    chk({tag, "_release"}, 32'(btn_release), 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    int run_left;
    logic rb;
    logic [W-1:0] rg;

    for (int i = 0; i < 20; i++) begin
      tbl[i].g  = 20'hA5A5A;
      tbl[i].b  = (i < 10) ? 1'b0 : 1'b1;
      tbl[i].eg = (i >= LAT - 1) ? 20'hA5A5A : 20'h0;
      tbl[i].el = (i >= 6) && (i < 16);
      tbl[i].ep = (i == 6);
      tbl[i].er = (i == 16);
    end

    rst_n       = 1'b0;
    gpio_in_raw = '0;
    btn_raw     = 1'b1;
    do_reset("rst");

    for (int i = 0; i < 20; i++) begin
      tick('0, 1'b1);
      chk("idle_gpio", 32'(gpio_in_sync), 32'd0);
      chk("idle_level", 32'(btn_level), 32'd0);
      chk("idle_press", 32'(btn_press), 32'd0);
      chk("idle_release", 32'(btn_release), 32'd0);
    end

    for (int i = 0; i < 20; i++) begin
      tick(tbl[i].g, tbl[i].b);
      chk("tbl_gpio", 32'(gpio_in_sync), 32'(tbl[i].eg));
      chk("tbl_level", 32'(btn_level), 32'(tbl[i].el));
      chk("tbl_press", 32'(btn_press), 32'(tbl[i].ep));
      chk("tbl_release", 32'(btn_release), 32'(tbl[i].er));
    end

    for (int i = 0; i < 13; i++) begin
      tick(20'hA5A5A, (i < 3) ? 1'b0 : 1'b1);
      chk("bounce_press", 32'(btn_press), 32'd0);
      chk("bounce_level", 32'(btn_level), 32'd0);
      chk("bounce_release", 32'(btn_release), 32'd0);
    end

    for (int i = 0; i < 5; i++) begin
      tick(20'hA5A5A, 1'b0);
      chk("chk_press", 32'(btn_press), 32'd0);
      chk("chk_level", 32'(btn_level), 32'd0);
    end
    do_reset("mid_rst");
    for (int i = 0; i < 10; i++) begin
      tick('0, 1'b1);
      chk("post_rst_press", 32'(btn_press), 32'd0);
      chk("post_rst_release", 32'(btn_release), 32'd0);
      chk("post_rst_level", 32'(btn_level), 32'd0);
    end
    for (int i = 0; i < 10; i++) begin
      tick('0, 1'b0);
      chk("fresh_press", 32'(btn_press), 32'(i == 6));
      chk("fresh_level", 32'(btn_level), 32'(i >= 6));
    end
    for (int i = 0; i < 10; i++) begin
      tick('0, 1'b1);
      chk_model("fresh_rel");
    end

    for (int i = 0; i < 5; i++) begin
      tick('0, 1'b1);
      chk_model("pre_glitch");
    end
    for (int j = 0; j < 9; j++) begin
      tick((j == 0) ? 20'h00080 : 20'h0, 1'b1);
      chk("glitch_bit7", 32'(gpio_in_sync[7]), FILT ? 32'd0 : 32'(j == LAT - 1));
      chk_model("glitch");
    end

    run_left = 0;
    rb       = 1'b1;
    rg       = '0;
    for (int i = 0; i < 800; i++) begin
      if (run_left == 0) begin
        rb       = 1'($urandom_range(0, 1));
        run_left = $urandom_range(1, 8);
      end
      run_left--;
      if ($urandom_range(0, 3) == 0) rg = W'($urandom);
      tick(rg, rb);
      chk_model("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
